// File: rtl/pau_arb.sv
// pau_arb: two-requester arbiter for a shared 1-cycle registered adder, optional grant counters via PAU_ARB_STATS_EN
module pau_arb #(
  parameter int NUM_LANES  = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                r0_valid,
  output logic                                r0_ready,
  input  logic [NUM_LANES*DATA_WIDTH-1:0]     r0_a,
  input  logic [NUM_LANES*DATA_WIDTH-1:0]     r0_b,
  output logic                                r0_rsp_valid,
  input  logic                                r0_rsp_ready,
  output logic [NUM_LANES*(DATA_WIDTH+1)-1:0] r0_rsp_p,
  input  logic                                r1_valid,
  output logic                                r1_ready,
  input  logic [NUM_LANES*DATA_WIDTH-1:0]     r1_a,
  input  logic [NUM_LANES*DATA_WIDTH-1:0]     r1_b,
  output logic                                r1_rsp_valid,
  input  logic                                r1_rsp_ready,
  output logic [NUM_LANES*(DATA_WIDTH+1)-1:0] r1_rsp_p,
  output logic [NUM_LANES*DATA_WIDTH-1:0]     pau_a_flat,
  output logic [NUM_LANES*DATA_WIDTH-1:0]     pau_b_flat,
  input  logic [NUM_LANES*(DATA_WIDTH+1)-1:0] pau_p_flat,
  output logic                                busy
`ifdef PAU_ARB_STATS_EN
  ,
  output logic [15:0]                         gnt_cnt0,
  output logic [15:0]                         gnt_cnt1
`endif
);
  logic inflight_vld, inflight_id, last_gnt;
  logic cand0, cand1, gnt0, gnt1, acc, cap0, cap1;
  // a requester is blocked while its own op is in flight or its result slot cannot drain
  always_comb begin
    cand0 = r0_valid && !(inflight_vld && !inflight_id) && (!r0_rsp_valid || r0_rsp_ready);
    cand1 = r1_valid && !(inflight_vld && inflight_id) && (!r1_rsp_valid || r1_rsp_ready);
    gnt0 = !rst && cand0 && (!cand1 || last_gnt);
    gnt1 = !rst && cand1 && (!cand0 || !last_gnt);
    acc = gnt0 || gnt1;
    cap0 = inflight_vld && !inflight_id;
    cap1 = inflight_vld && inflight_id;
    r0_ready = gnt0;
    r1_ready = gnt1;
    pau_a_flat = gnt0 ? r0_a : gnt1 ? r1_a : '0;
    pau_b_flat = gnt0 ? r0_b : gnt1 ? r1_b : '0;
    busy = inflight_vld || r0_rsp_valid || r1_rsp_valid;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_vld <= 1'b0;
      inflight_id <= 1'b0;
      last_gnt <= 1'b1;
      r0_rsp_valid <= 1'b0;
      r1_rsp_valid <= 1'b0;
      r0_rsp_p <= '0;
      r1_rsp_p <= '0;
    end else begin
      inflight_vld <= acc;
      if (acc) begin
        inflight_id <= gnt1;
        last_gnt <= gnt1;
      end
      r0_rsp_valid <= cap0 || (r0_rsp_valid && !r0_rsp_ready);
      r1_rsp_valid <= cap1 || (r1_rsp_valid && !r1_rsp_ready);
      if (cap0) r0_rsp_p <= pau_p_flat;
      if (cap1) r1_rsp_p <= pau_p_flat;
    end
  end
`ifdef PAU_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
    end else begin
      gnt_cnt0 <= gnt_cnt0 + 16'(gnt0);
      gnt_cnt1 <= gnt_cnt1 + 16'(gnt1);
    end
  end
`endif
endmodule
